morph_program_sequencer: RTL and testbench

//  Initiator side of the morphologic processor's instruction interface. Latches a

---
 rtl/morph_proc_if.sv | 43 ++++
 rtl/morph_program_sequencer.sv | 153 +++++++++++++++
 tb/tb_morph_program_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/morph_proc_if.sv
// Instruction/image link between the program sequencer and the
// morphologic processor.
interface morph_proc_if #(
    parameter int ImageWidth     = 16,
    parameter int ImageHeight    = 16,
    parameter int OpCounterWidth = 2
) ();
    logic                              proc_clr;
    logic                              proc_ce;
    logic [ImageWidth*ImageHeight-1:0] proc_image;
    logic [8:0]                        proc_el;
    logic [2:0]                        proc_morphOp;
    logic                              proc_morphInSel;
    logic [2:0]                        proc_logicOp;
    logic [OpCounterWidth-1:0]         proc_opCounter;
    logic [ImageWidth*ImageHeight-1:0] proc_imageAcc;

    // Sequencer side: drives control and instruction fields.
    modport master (
        output proc_clr,
        output proc_ce,
        output proc_image,
        output proc_el,
        output proc_morphOp,
        output proc_morphInSel,
        output proc_logicOp,
        input  proc_opCounter,
        input  proc_imageAcc
    );

    // Processor side.
    modport slave (
        input  proc_clr,
        input  proc_ce,
        input  proc_image,
        input  proc_el,
        input  proc_morphOp,
        input  proc_morphInSel,
        input  proc_logicOp,
        output proc_opCounter,
        output proc_imageAcc
    );
endinterface

// File: rtl/morph_program_sequencer.sv
// Drives one chromosome through the morphologic processor:
// latch, clear, issue one instruction per ce cycle, capture.
module morph_program_sequencer #(
    parameter int ImageWidth     = 16,
    parameter int ImageHeight    = 16,
    parameter int OpCounterWidth = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic                                 pause_i,
    input  logic [OpCounterWidth:0]              prog_len_i,
    input  logic [(2**OpCounterWidth)*16-1:0]    program_i,
    input  logic [ImageWidth*ImageHeight-1:0]    image_in_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 err_o,
    output logic [ImageWidth*ImageHeight-1:0]    result_o,
    morph_proc_if.master                         proc
);

    localparam int NumOps = 2 ** OpCounterWidth;
    localparam int ImgBits = ImageWidth * ImageHeight;
    localparam int ProgBits = NumOps * 16;

    localparam logic [OpCounterWidth:0] LenMax =
        {1'b1, {OpCounterWidth{1'b0}}};
    localparam logic [OpCounterWidth:0] LenOne =
        {{OpCounterWidth{1'b0}}, 1'b1};
    localparam logic [OpCounterWidth-1:0] IdxOne =
        {{(OpCounterWidth-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPTURE
    } state_t;

    state_t                    state_q, state_d;
    logic [ProgBits-1:0]       prog_q, prog_d;
    logic [OpCounterWidth:0]   len_q, len_d;
    logic [ImgBits-1:0]        img_q, img_d;
    logic [OpCounterWidth-1:0] idx_q, idx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic [ImgBits-1:0]        result_q, result_d;
    logic                      clr_q, clr_d;

    logic                      ce;
    logic                      last;
    logic [15:0]               instr;

    // Next-state, issue control and instruction selection.
    always_comb begin
        state_d  = state_q;
        prog_d   = prog_q;
        len_d    = len_q;
        img_d    = img_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        result_d = result_q;
        clr_d    = 1'b0;
        ce       = 1'b0;
        instr    = 16'h0000;
        last     = ({1'b0, idx_q} == (len_q - LenOne));

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    prog_d  = program_i;
                    // Oversized lengths would never reach the last index.
                    len_d   = (prog_len_i > LenMax) ? LenMax : prog_len_i;
                    img_d   = image_in_i;
                    busy_d  = 1'b1;
                    clr_d   = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                idx_d   = '0;
                state_d = (len_q == '0) ? S_CAPTURE : S_RUN;
            end
            S_RUN: begin
                ce    = ~pause_i;
                instr = prog_q[{idx_q, 4'b0000} +: 16];
                if (ce) begin
                    idx_d = idx_q + IdxOne;
                    if (last) begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                // An empty program returns the source image untouched.
                result_d = (len_q == '0) ? img_q : proc.proc_imageAcc;
                // Full-length programs wrap the op counter back to zero.
                err_d    = (len_q != '0) &&
                           (proc.proc_opCounter != len_q[OpCounterWidth-1:0]);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            prog_q   <= '0;
            len_q    <= '0;
            img_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prog_q   <= prog_d;
            len_q    <= len_d;
            img_q    <= img_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            clr_q    <= clr_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign result_o = result_q;

    assign proc.proc_clr        = clr_q;
    assign proc.proc_ce         = ce;
    assign proc.proc_image      = img_q;
    assign proc.proc_el         = instr[15:7];
    assign proc.proc_morphOp    = instr[6:4];
    assign proc.proc_morphInSel = instr[3];
    assign proc.proc_logicOp    = instr[2:0];

endmodule

// File: tb/tb_morph_program_sequencer.sv
// Bench for morph_program_sequencer with a stand-in processor
// and an instruction-order / latency reference model.
module tb_morph_program_sequencer;

    localparam int NOPS = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         pause;
    logic [2:0]   prog_len;
    logic [63:0]  program_v;
    logic [255:0] image_in;
    logic         busy, done, err;
    logic [255:0] result;

    int checks = 0;
    int errors = 0;

    morph_proc_if #(
        .ImageWidth(16), .ImageHeight(16), .OpCounterWidth(2)
    ) pif ();

    morph_program_sequencer #(
        .ImageWidth(16), .ImageHeight(16), .OpCounterWidth(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .pause_i    (pause),
        .prog_len_i (prog_len),
        .program_i  (program_v),
        .image_in_i (image_in),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .result_o   (result),
        .proc       (pif)
    );

    always #5 clk = ~clk;

    // Toy processor: each issued op folds the image and instruction
    // into the accumulator so that order and count are visible.
    function automatic logic [255:0] step(input logic [255:0] a,
                                          input logic [255:0] img,
                                          input logic [15:0] ins);
        return {a[254:0], a[255]} ^ img ^ {16{ins}};
    endfunction

    function automatic logic [255:0] model_acc(input int len,
                                               input logic [63:0] prog,
                                               input logic [255:0] img);
        logic [255:0] a;
        a = '0;
        for (int i = 0; i < len; i++) a = step(a, img, prog[i*16 +: 16]);
        if (len == 0) a = img;
        return a;
    endfunction

    logic [255:0] acc;
    logic [1:0]   oc;
    logic         force_en;
    logic [1:0]   force_val;
    logic [15:0]  instr_w;
    logic [15:0]  issued_q[$];

    assign instr_w = {pif.proc_el, pif.proc_morphOp,
                      pif.proc_morphInSel, pif.proc_logicOp};
    assign pif.proc_imageAcc  = acc;
    assign pif.proc_opCounter = force_en ? force_val : oc;

    // Processor reset is rst ORed with the sequencer clear pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            oc  <= '0;
        end else if (pif.proc_clr) begin
            acc <= '0;
            oc  <= '0;
        end else if (pif.proc_ce) begin
            acc <= step(acc, pif.proc_image, instr_w);
            oc  <= oc + 2'd1;
            issued_q.push_back(instr_w);
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One run: pmode 0 = no pause, 1 = random pause, 2 = pause in
    // RUN cycles 2 and 3. Returns in the done cycle.
    task automatic run(input int len, input logic [63:0] prog,
                       input logic [255:0] img, input int pmode,
                       input bit hold);
        logic [255:0] exp_acc;
        bit           exp_err;
        int           issued;
        int           n;
        int           done_at;
        bit           seen;
        bit           in_run;
        exp_acc = model_acc(len, prog, img);
        exp_err = (len != 0) &&
                  ((force_en ? int'(force_val) : len % NOPS) != len % NOPS);
        issued_q.delete();
        @(negedge clk);
        start     = 1'b1;
        prog_len  = 3'(len);
        program_v = prog;
        image_in  = img;
        pause     = 1'b0;
        @(negedge clk);
        if (!hold) start = 1'b0;
        issued  = 0;
        n       = 0;
        seen    = 1'b0;
        done_at = (len == 0) ? 2 : -1;
        while (!seen && n < 64) begin
            in_run = (n >= 1) && (issued < len);
            case (pmode)
                0:       pause = 1'b0;
                1:       pause = ($urandom_range(0, 2) == 0);
                default: pause = (n == 2 || n == 3);
            endcase
            #1;
            if (n == done_at) begin
                chk("done", 256'(done), 256'(1));
                chk("busy_done", 256'(busy), 256'(0));
                chk("result", result, exp_acc);
                chk("err", 256'(err), 256'(exp_err));
                chk("ce_done", 256'(pif.proc_ce), 256'(0));
                seen = 1'b1;
            end else begin
                chk("done_low", 256'(done), 256'(0));
                chk("busy", 256'(busy), 256'(1));
                chk("ce", 256'(pif.proc_ce), 256'(in_run && !pause));
                chk("clr", 256'(pif.proc_clr), 256'(n == 0));
                chk("image", pif.proc_image, img);
                if (in_run)
                    chk("instr", 256'(instr_w), 256'(prog[issued*16 +: 16]));
                else
                    chk("instr_idle", 256'(instr_w), 256'(0));
                if (in_run && !pause) begin
                    issued++;
                    if (issued == len) done_at = n + 2;
                end
                @(negedge clk);
                n++;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL timeout: no done after %0d cycles", n);
        end
        chk("issue_count", 256'(issued_q.size()), 256'(len));
        for (int i = 0; i < len && i < issued_q.size(); i++)
            chk("issue_order", 256'(issued_q[i]), 256'(prog[i*16 +: 16]));
    endtask

    initial begin
        logic [63:0]  p;
        logic [255:0] im;
        int           len;
        bit           seen;

        rst       = 1'b1;
        start     = 1'b0;
        pause     = 1'b0;
        prog_len  = '0;
        program_v = '0;
        image_in  = '0;
        force_en  = 1'b0;
        force_val = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_result", result, 256'(0));
        chk("rst_clr", 256'(pif.proc_clr), 256'(0));
        chk("rst_ce", 256'(pif.proc_ce), 256'(0));
        chk("rst_image", pif.proc_image, 256'(0));
        chk("rst_instr", 256'(instr_w), 256'(0));
        rst = 1'b0;

        // Four dilate/AND ops, 3x3 all-ones element, single pixel.
        run(4, {4{16'hFF91}}, 256'(1) << 119, 0, 1'b0);

        // Empty program passes the source image through.
        run(0, 64'hDEAD_BEEF_0123_4567, {32{8'hA5}}, 0, 1'b0);

        // Two pause cycles in the middle of a three-op run.
        run(3, 64'h0000_1111_2222_3333, {8{32'h1234_5678}}, 2, 1'b0);

        // Processor op counter disagrees at capture.
        force_en  = 1'b1;
        force_val = 2'd1;
        run(2, 64'h0000_0000_ABCD_5A5A, {16{16'h0F0F}}, 0, 1'b0);
        force_en  = 1'b0;

        // Reset in the middle of RUN aborts without done.
        @(negedge clk);
        start     = 1'b1;
        prog_len  = 3'd4;
        program_v = 64'h1111_2222_3333_4444;
        image_in  = {8{32'hCAFE_F00D}};
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_done", 256'(done), 256'(0));
        chk("abort_ce", 256'(pif.proc_ce), 256'(0));
        chk("abort_result", result, 256'(0));
        chk("abort_image", pif.proc_image, 256'(0));
        chk("abort_instr", 256'(instr_w), 256'(0));
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 256'(seen), 256'(0));

        // Start held through done: second run starts on the done cycle.
        p  = 64'h0102_0304_0506_0708;
        im = {8{32'h8000_0001}};
        run(3, p, im, 0, 1'b1);
        @(negedge clk);
        #1;
        chk("b2b_busy", 256'(busy), 256'(1));
        chk("b2b_clr", 256'(pif.proc_clr), 256'(1));
        chk("b2b_done_low", 256'(done), 256'(0));
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("b2b_done", 256'(seen), 256'(1));
        chk("b2b_result", result, model_acc(3, p, im));

        // Random programs, lengths, images, pauses and counter faults.
        for (int t = 0; t < 20; t++) begin
            len = int'($urandom_range(0, 4));
            p   = {$urandom, $urandom};
            for (int w = 0; w < 8; w++) im[w*32 +: 32] = $urandom;
            force_en  = ($urandom_range(0, 3) == 0);
            force_val = 2'($urandom_range(0, 3));
            run(len, p, im, 1, 1'b0);
        end
        force_en = 1'b0;

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
